// File: rtl/if_id_fetch.sv
`default_nettype none
// ============================================================================
// if_id_fetch : instruction-bus master for the fetch stage + IF/ID register
// Rev 1.0
// ============================================================================
module if_id_fetch #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] pc_add_4_in,
  input  logic             is_newPC,
  input  logic             stallD,
  input  logic             flushD,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  output logic             fetch_stall,
  output logic [WIDTH-1:0] instrD,
  output logic [WIDTH-1:0] pcD,
  output logic [WIDTH-1:0] pc_add_4D,
  output logic             validD,
  output logic             addr_errD
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             discard_q, discard_d;
  logic             inst_req_q, inst_req_d;
  logic [WIDTH-1:0] inst_addr_q, inst_addr_d;
  logic [WIDTH-1:0] req_pc4_q, req_pc4_d;

  logic [WIDTH-1:0] buf_instr_q, buf_instr_d;
  logic [WIDTH-1:0] buf_pc_q, buf_pc_d;
  logic [WIDTH-1:0] buf_pc4_q, buf_pc4_d;
  logic             buf_err_q, buf_err_d;

  logic [WIDTH-1:0] d_instr_q, d_instr_d;
  logic [WIDTH-1:0] d_pc_q, d_pc_d;
  logic [WIDTH-1:0] d_pc4_q, d_pc4_d;
  logic             d_valid_q, d_valid_d;
  logic             d_err_q, d_err_d;

  logic             xfer;
  logic             unused_inputs;

  // The PC stage only reaches us through pc_in while fetch_stall holds it.
  assign unused_inputs = is_newPC;

  assign xfer        = (state_q == S_HOLD) && !stallD && !flushD;
  assign fetch_stall = !xfer;

  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    inst_addr_d = inst_addr_q;
    req_pc4_d   = req_pc4_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_pc4_d   = buf_pc4_q;
    buf_err_d   = buf_err_q;

    case (state_q)
      S_IDLE: begin
        inst_addr_d = {pc_in[WIDTH-1:2], 2'b00};
        req_pc4_d   = pc_add_4_in;
        if (pc_in[1:0] != 2'b00) begin
          // Misaligned PC never reaches the bus; it goes out as an AdEL bubble.
          state_d     = S_HOLD;
          buf_instr_d = NOP_INSTR;
          buf_pc_d    = pc_in;
          buf_pc4_d   = pc_add_4_in;
          buf_err_d   = 1'b1;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (flushD) begin
          discard_d = 1'b1;
        end
        if (inst_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          discard_d = 1'b0;
          if (discard_q || flushD) begin
            state_d = S_IDLE;
          end else begin
            state_d     = S_HOLD;
            buf_instr_d = inst_rdata;
            buf_pc_d    = inst_addr_q;
            buf_pc4_d   = req_pc4_q;
            buf_err_d   = 1'b0;
          end
        end else if (flushD) begin
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (flushD || !stallD) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    inst_req_d = (state_d == S_REQ);
  end

  // IF/ID register: flush beats stall beats transfer; otherwise a bubble.
  always_comb begin
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    d_pc4_d   = d_pc4_q;
    d_valid_d = d_valid_q;
    d_err_d   = d_err_q;
    if (flushD) begin
      d_instr_d = NOP_INSTR;
      d_valid_d = 1'b0;
      d_err_d   = 1'b0;
    end else if (!stallD) begin
      if (state_q == S_HOLD) begin
        d_instr_d = buf_instr_q;
        d_pc_d    = buf_pc_q;
        d_pc4_d   = buf_pc4_q;
        d_valid_d = 1'b1;
        d_err_d   = buf_err_q;
      end else begin
        d_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      discard_q   <= 1'b0;
      inst_req_q  <= 1'b0;
      inst_addr_q <= '0;
      req_pc4_q   <= '0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= '0;
      buf_pc4_q   <= '0;
      buf_err_q   <= 1'b0;
      d_instr_q   <= NOP_INSTR;
      d_pc_q      <= '0;
      d_pc4_q     <= '0;
      d_valid_q   <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      inst_req_q  <= inst_req_d;
      inst_addr_q <= inst_addr_d;
      req_pc4_q   <= req_pc4_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      buf_pc4_q   <= buf_pc4_d;
      buf_err_q   <= buf_err_d;
      d_instr_q   <= d_instr_d;
      d_pc_q      <= d_pc_d;
      d_pc4_q     <= d_pc4_d;
      d_valid_q   <= d_valid_d;
      d_err_q     <= d_err_d;
    end
  end

  assign inst_req  = inst_req_q;
  assign inst_addr = inst_addr_q;
  assign instrD    = d_instr_q;
  assign pcD       = d_pc_q;
  assign pc_add_4D = d_pc4_q;
  assign validD    = d_valid_q;
  assign addr_errD = d_err_q;

endmodule
`default_nettype wire

// File: tb/tb_if_id_fetch.sv
`default_nettype none
// ============================================================================
// tb_if_id_fetch : directed + random bench with a PC-stage / bus / IF-ID model
// Rev 1.0
// ============================================================================
module tb_if_id_fetch;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int          WD_LIMIT = 150;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, pc_add_4_in;
  logic        is_newPC, stallD, flushD;
  logic        inst_req, inst_addr_ok, inst_data_ok, fetch_stall;
  logic [31:0] inst_addr, inst_rdata, instrD, pcD, pc_add_4D;
  logic        validD, addr_errD;

  always #5 clk = ~clk;
  assign pc_add_4_in = pc_in + 32'd4;

  if_id_fetch #(.WIDTH(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_add_4_in(pc_add_4_in),
    .is_newPC(is_newPC), .stallD(stallD), .flushD(flushD),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .fetch_stall(fetch_stall),
    .instrD(instrD), .pcD(pcD), .pc_add_4D(pc_add_4D), .validD(validD),
    .addr_errD(addr_errD)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected next delivered PC and a simple memory bus
  logic [31:0] exp_pc;
  int          a_lat, d_lat, txn_a, txn_d, addr_cnt, data_cnt;
  bit          req_seen, pending;
  logic [31:0] pend_addr;
  int          cyc, last_deliv, reqcnt, fslow;
  bit          clean, delivered, stale_seen, wd_tripped;

  bit          p_stall, p_flush, p_fs, p_req, p_aok, p_valid, p_err;
  logic [31:0] p_tgt, p_addr, p_instr, p_pc, p_pc4;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'hbfc0_0000) return 32'h2408_0001;
    if (a == 32'hbfc0_0008) return 32'hdead_beef;
    return {a[15:0], a[31:16]} ^ 32'h3c1d_a5a5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive_bus();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = $urandom;
    if (pending) begin
      chk1("one_outstanding", inst_req, 1'b0);
      if (data_cnt == 0) begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem(pend_addr);
        pending      = 1'b0;
      end else begin
        data_cnt--;
      end
    end else if (inst_req) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        addr_cnt = a_lat;
        txn_a    = a_lat;
        txn_d    = d_lat;
      end
      if (addr_cnt == 0) begin
        inst_addr_ok = 1'b1;
        pend_addr    = inst_addr;
        pending      = 1'b1;
        data_cnt     = txn_d;
        req_seen     = 1'b0;
      end else begin
        addr_cnt--;
      end
    end
  endtask

  task automatic post_checks();
    logic        mis;
    delivered = 1'b0;
    if (instrD === 32'hdead_beef) stale_seen = 1'b1;
    if (p_req && !p_aok) begin
      chk1("req_hold", inst_req, 1'b1);
      chk("addr_stable", inst_addr, p_addr);
    end
    if (p_flush) begin
      chk1("flush_valid", validD, 1'b0);
      chk("flush_instr", instrD, NOP);
      chk1("flush_err", addr_errD, 1'b0);
      chk("flush_pc", pcD, p_pc);
      exp_pc     = p_tgt;
      clean      = 1'b0;
      last_deliv = cyc;
    end else if (p_stall) begin
      chk1("stall_valid", validD, p_valid);
      chk("stall_instr", instrD, p_instr);
      chk("stall_pc", pcD, p_pc);
      chk("stall_pc4", pc_add_4D, p_pc4);
      chk1("stall_err", addr_errD, p_err);
      clean = 1'b0;
    end else if (validD) begin
      mis       = (exp_pc[1:0] != 2'b00);
      delivered = 1'b1;
      chk1("d_fs_before", p_fs, 1'b0);
      chk("d_pc", pcD, exp_pc);
      chk("d_pc4", pc_add_4D, exp_pc + 32'd4);
      chk1("d_err", addr_errD, mis);
      chk("d_instr", instrD, mis ? NOP : mem(exp_pc));
      if (clean) chk("d_interval", 32'(cyc - last_deliv), mis ? 32'd2 : 32'(4 + txn_a + txn_d));
      last_deliv = cyc;
      clean      = 1'b1;
      exp_pc     = exp_pc + 32'd4;
    end else begin
      chk1("bubble_fs", p_fs, 1'b1);
    end
    if (inst_req && !p_req) chk("req_addr", inst_addr, exp_pc);
  endtask

  // One clock: drive at the falling edge, check after the next rising edge.
  task automatic step(input bit stall, input bit flush, input logic [31:0] tgt);
    stallD = stall;
    flushD = flush;
    drive_bus();
    #1;
    if (stall || flush) chk1("fs_comb", fetch_stall, 1'b1);
    if (inst_req) reqcnt++;
    if (!fetch_stall) fslow++;
    p_stall = stall;        p_flush = flush;     p_tgt = tgt;
    p_fs    = fetch_stall;  p_req   = inst_req;  p_aok = inst_addr_ok;
    p_addr  = inst_addr;    p_instr = instrD;    p_pc  = pcD;
    p_pc4   = pc_add_4D;    p_valid = validD;    p_err = addr_errD;
    @(negedge clk);
    cyc++;
    post_checks();
    is_newPC = p_flush || !p_fs;
    if (p_flush) pc_in = p_tgt;
    else if (!p_fs) pc_in = pc_add_4_in;
    n_checks++;
    assert (cyc - last_deliv <= WD_LIMIT) else begin
      n_fail++;
      wd_tripped = 1'b1;
      $error("FAIL watchdog observed=%0d idle cycles expected<=%0d", cyc - last_deliv, WD_LIMIT);
    end
  endtask

  task automatic wait_deliv(input int bound);
    int n = 0;
    do begin
      step(1'b0, 1'b0, 32'd0);
      n++;
    end while (!delivered && n < bound);
    n_checks++;
    assert (delivered) else begin
      n_fail++;
      $error("FAIL wait_deliv observed=none expected=delivery within %0d cycles", bound);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] tgt;
    bit          st, fl;
    rst = 1'b1; pc_in = 32'hbfc0_0000; is_newPC = 1'b0; stallD = 1'b0; flushD = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    a_lat = 0; d_lat = 0; txn_a = 0; txn_d = 0; addr_cnt = 0; data_cnt = 0;
    req_seen = 1'b0; pending = 1'b0; pend_addr = '0;
    cyc = 0; last_deliv = 0; reqcnt = 0; fslow = 0;
    clean = 1'b0; delivered = 1'b0; stale_seen = 1'b0; wd_tripped = 1'b0;
    p_stall = 1'b0; p_flush = 1'b0; p_fs = 1'b1; p_req = 1'b0; p_aok = 1'b0;
    p_valid = 1'b0; p_err = 1'b0; p_tgt = '0; p_addr = '0; p_instr = '0; p_pc = '0; p_pc4 = '0;
    repeat (3) @(negedge clk);

    chk1("rst_req", inst_req, 1'b0);
    chk("rst_addr", inst_addr, 32'd0);
    chk("rst_instr", instrD, NOP);
    chk("rst_pc", pcD, 32'd0);
    chk("rst_pc4", pc_add_4D, 32'd0);
    chk1("rst_valid", validD, 1'b0);
    chk1("rst_err", addr_errD, 1'b0);
    chk1("rst_fs", fetch_stall, 1'b1);
    rst    = 1'b0;
    exp_pc = pc_in;

    // 1: zero-wait fetch of the reset vector
    step(0, 0, 0); chk1("t1_fs_idle", p_fs, 1'b1);
    chk1("t1_req", inst_req, 1'b1);
    chk("t1_addr", inst_addr, 32'hbfc0_0000);
    step(0, 0, 0); chk1("t1_fs_req", p_fs, 1'b1);
    step(0, 0, 0); chk1("t1_fs_wait", p_fs, 1'b1);
    step(0, 0, 0); chk1("t1_fs_hold", p_fs, 1'b0);
    chk("t1_instr", instrD, 32'h2408_0001);
    chk("t1_pc", pcD, 32'hbfc0_0000);
    chk("t1_pc4", pc_add_4D, 32'hbfc0_0004);
    chk1("t1_valid", validD, 1'b1);
    a_lat = 3; d_lat = 2;
    step(0, 0, 0); chk1("t1_fs_after", p_fs, 1'b1);

    // 2: slow bus, addr_ok after 3 cycles and data_ok 2 further cycles
    reqcnt = 0; fslow = 0;
    wait_deliv(30);
    chk("t2_req_cycles", 32'(reqcnt), 32'd4);
    chk("t2_fs_low", 32'(fslow), 32'd1);
    chk("t2_pc", pcD, 32'hbfc0_0004);

    // 3: flush while waiting; the stale word must be dropped
    a_lat = 0; d_lat = 2; stale_seen = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 32'hbfc0_0380);
    wait_deliv(30);
    chk("t3_pc", pcD, 32'hbfc0_0380);
    chk("t3_instr", instrD, mem(32'hbfc0_0380));
    chk1("t3_no_stale", stale_seen, 1'b0);

    // 4: decode stalls a full buffer for 4 cycles
    d_lat = 0;
    repeat (3) step(0, 0, 0);
    repeat (4) step(1, 0, 0);
    chk("t4_frozen_pc", pcD, 32'hbfc0_0380);
    step(0, 0, 0);
    chk1("t4_fs", p_fs, 1'b0);
    chk1("t4_valid", validD, 1'b1);
    chk("t4_pc", pcD, 32'hbfc0_0384);

    // 5: redirect to a misaligned PC
    step(0, 0, 0);
    step(0, 1, 32'hbfc0_0002);
    reqcnt = 0;
    wait_deliv(20);
    chk("t5_no_req", 32'(reqcnt), 32'd0);
    chk1("t5_valid", validD, 1'b1);
    chk1("t5_err", addr_errD, 1'b1);
    chk("t5_instr", instrD, 32'd0);
    chk("t5_pc", pcD, 32'hbfc0_0002);

    // 6: flush and stall together while holding
    step(0, 0, 0);
    step(1, 1, 32'hbfc0_0400);
    chk1("t6_valid", validD, 1'b0);
    chk("t6_instr", instrD, NOP);
    chk("t6_pc_kept", pcD, 32'hbfc0_0002);
    wait_deliv(20);
    chk("t6_refetch_pc", pcD, 32'hbfc0_0400);
    chk1("t6_refetch_err", addr_errD, 1'b0);

    // Random traffic: bus latencies, decode stalls, flushes while the bus is busy
    for (int i = 0; i < 1500 && !wd_tripped; i++) begin
      a_lat = $urandom_range(0, 3);
      d_lat = $urandom_range(0, 3);
      st    = ($urandom_range(0, 3) == 0);
      fl    = (inst_req || pending) && ($urandom_range(0, 15) == 0);
      r     = $urandom;
      tgt   = {16'h0040, r[15:2], 2'b00};
      step(st, fl, tgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
